// File: rtl/v_ioport_gen.sv
// v_ioport_gen: 6510-style CPU I/O port (DDR/DATA) with pin-change interrupt flags/masks
// and capacitive fade retention on register bits that have no physical pin.
module v_ioport_gen #(
    parameter int unsigned AW        = 16,
    parameter int unsigned BASE      = 0,
    parameter int unsigned REG_W     = 8,
    parameter int unsigned PIN_W     = 6,
    parameter int unsigned EXT_REGS  = 1,
    parameter int unsigned EDGE_MODE = 0,
    parameter int unsigned FADE_CYC  = 0,
    parameter int unsigned FADE_BITS = 16
) (
    input  logic             phi2,
    input  logic             _reset,
    input  logic [AW-1:0]    address,
    input  logic             r_w,
    input  logic             aec,
    input  logic [REG_W-1:0] data_in,
    output logic [REG_W-1:0] data_out,
    output logic             sel,
    input  logic [PIN_W-1:0] pin_in,
    output logic [PIN_W-1:0] pin_out,
    output logic [PIN_W-1:0] pin_oe,
    output logic             irq_n
);

    localparam logic [AW-1:0]        BaseAddr = AW'(BASE);
    localparam logic [FADE_BITS-1:0] FadeLoad = FADE_BITS'(FADE_CYC);
    localparam logic [FADE_BITS-1:0] FadeOne  = FADE_BITS'(1);

    localparam logic [1:0] OffDdr   = 2'd0;
    localparam logic [1:0] OffData  = 2'd1;
    localparam logic [1:0] OffIflag = 2'd2;
    localparam logic [1:0] OffImask = 2'd3;

    logic [REG_W-1:0] ddr_q, ddr_d;
    logic [REG_W-1:0] data_q, data_d;
    logic [PIN_W-1:0] iflag_q, iflag_d;
    logic [PIN_W-1:0] imask_q, imask_d;
    logic [PIN_W-1:0] sync1_q, sync2_q, prev_q;
    logic [REG_W-1:0] cap_q, cap_d;
    logic [REG_W-1:0][FADE_BITS-1:0] cnt_q, cnt_d;

    logic [1:0]       offset;
    logic             wr_en;
    logic [PIN_W-1:0] edge_hit;
    logic [PIN_W-1:0] clr_mask;
    logic [REG_W-1:0] pin_ext;
    logic [REG_W-1:0] data_rd;

    // Address decode: 4-register window with the extended registers, 2-register otherwise.
    always_comb begin
        if (EXT_REGS != 0) begin
            sel    = (address[AW-1:2] == BaseAddr[AW-1:2]);
            offset = address[1:0];
        end else begin
            sel    = (address[AW-1:1] == BaseAddr[AW-1:1]);
            offset = {1'b0, address[0]};
        end
    end

    assign wr_en = sel & ~r_w & aec;

    always_comb begin
        if (EDGE_MODE == 1) begin
            edge_hit = prev_q & ~sync2_q;
        end else if (EDGE_MODE == 2) begin
            edge_hit = ~prev_q & sync2_q;
        end else begin
            edge_hit = prev_q ^ sync2_q;
        end
    end

    always_comb begin
        ddr_d    = ddr_q;
        data_d   = data_q;
        imask_d  = imask_q;
        clr_mask = '0;
        if (wr_en) begin
            case (offset)
                OffDdr:   ddr_d    = data_in;
                OffData:  data_d   = data_in;
                OffIflag: clr_mask = data_in[PIN_W-1:0];
                OffImask: imask_d  = data_in[PIN_W-1:0];
                default:  ;
            endcase
        end
        // A detected change outranks a same-edge W1C; output pins never flag.
        iflag_d = (iflag_q & ~clr_mask) | (edge_hit & ~ddr_q[PIN_W-1:0]);
    end

    // Fade works from the pre-edge DDR/DATA so a same-edge write cannot shorten retention.
    always_comb begin
        cap_d = cap_q;
        cnt_d = cnt_q;
        for (int unsigned i = PIN_W; i < REG_W; i++) begin
            if (ddr_q[i]) begin
                if (FADE_CYC != 0) begin
                    cap_d[i] = data_q[i];
                end
                cnt_d[i] = FadeLoad;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - FadeOne;
                if (cnt_q[i] == FadeOne) begin
                    cap_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(negedge phi2 or negedge _reset) begin
        if (!_reset) begin
            ddr_q   <= '0;
            data_q  <= '0;
            iflag_q <= '0;
            imask_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            ddr_q   <= ddr_d;
            data_q  <= data_d;
            iflag_q <= iflag_d;
            imask_q <= imask_d;
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pin_ext = REG_W'(sync2_q);
        for (int unsigned i = 0; i < REG_W; i++) begin
            if (ddr_q[i]) begin
                data_rd[i] = data_q[i];
            end else if (i < PIN_W) begin
                data_rd[i] = pin_ext[i];
            end else begin
                data_rd[i] = cap_q[i];
            end
        end
    end

    always_comb begin
        data_out = '0;
        if (sel && r_w) begin
            case (offset)
                OffDdr:   data_out = ddr_q;
                OffData:  data_out = data_rd;
                OffIflag: data_out = REG_W'(iflag_q);
                OffImask: data_out = REG_W'(imask_q);
                default:  data_out = '0;
            endcase
        end
    end

    assign pin_out = data_q[PIN_W-1:0];
    assign pin_oe  = ddr_q[PIN_W-1:0];
    assign irq_n   = ~|(iflag_q & imask_q);

endmodule

// File: tb/tb_v_ioport_gen.sv
// Bench for v_ioport_gen: u0 = extended regs, falling-edge detect, 4-cycle fade;
// u1 = 2-register 6510 decode, any-edge detect, no fade. Both share the CPU/pin inputs.
module tb_v_ioport_gen;

    logic        phi2;
    logic        rst_n;
    logic [15:0] address;
    logic        r_w;
    logic        aec;
    logic [7:0]  data_in;
    logic [5:0]  pin_in;

    logic [7:0] d0_out, d1_out;
    logic       s0, s1;
    logic [5:0] po0, po1, oe0, oe1;
    logic       irq0, irq1;

    int n_cmp = 0;
    int n_bad = 0;

    v_ioport_gen #(.EXT_REGS(1), .EDGE_MODE(1), .FADE_CYC(4)) u0 (
        .phi2(phi2), ._reset(rst_n), .address(address), .r_w(r_w), .aec(aec),
        .data_in(data_in), .data_out(d0_out), .sel(s0), .pin_in(pin_in),
        .pin_out(po0), .pin_oe(oe0), .irq_n(irq0)
    );

    v_ioport_gen #(.EXT_REGS(0), .EDGE_MODE(0), .FADE_CYC(0)) u1 (
        .phi2(phi2), ._reset(rst_n), .address(address), .r_w(r_w), .aec(aec),
        .data_in(data_in), .data_out(d1_out), .sel(s1), .pin_in(pin_in),
        .pin_out(po1), .pin_oe(oe1), .irq_n(irq1)
    );

    initial begin
        phi2 = 1'b1;
        forever #10 phi2 = ~phi2;
    end

    // Reference model: register contents, a history of sampled pin values and, per
    // pinless bit, the number of edges since its DDR bit was last seen high.
    logic [7:0] m_ddr [2];
    logic [7:0] m_data [2];
    logic [5:0] m_flag [2];
    logic [5:0] m_mask [2];
    logic [5:0] m_hist [3];
    int         m_since [2][8];
    logic       m_last [2][8];

    function automatic int fade_of(input int m);
        return (m == 0) ? 4 : 0;
    endfunction

    function automatic bit m_sel(input int m);
        if (m == 0) return address[15:2] == 14'd0;
        return address[15:1] == 15'd0;
    endfunction

    function automatic logic [1:0] m_off(input int m);
        if (m == 0) return address[1:0];
        return {1'b0, address[0]};
    endfunction

    function automatic bit m_wr(input int m);
        return m_sel(m) && !r_w && aec;
    endfunction

    function automatic logic [5:0] m_det(input int m);
        logic [5:0] d;
        for (int i = 0; i < 6; i++) begin
            if (m == 0) d[i] = m_hist[2][i] && !m_hist[1][i];
            else        d[i] = m_hist[2][i] != m_hist[1][i];
            if (m_ddr[m][i]) d[i] = 1'b0;
        end
        return d;
    endfunction

    function automatic logic [7:0] m_read(input int m);
        logic [7:0] v;
        v = 8'h00;
        if (!m_sel(m) || !r_w) return 8'h00;
        case (m_off(m))
            2'd0: v = m_ddr[m];
            2'd1: begin
                for (int i = 0; i < 8; i++) begin
                    if (m_ddr[m][i])  v[i] = m_data[m][i];
                    else if (i < 6)   v[i] = m_hist[1][i];
                    else              v[i] = (m_since[m][i] < fade_of(m)) ? m_last[m][i] : 1'b0;
                end
            end
            2'd2:    v = {2'b00, m_flag[m]};
            default: v = {2'b00, m_mask[m]};
        endcase
        return v;
    endfunction

    always @(negedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                m_ddr[m]  <= 8'h00;
                m_data[m] <= 8'h00;
                m_flag[m] <= 6'h00;
                m_mask[m] <= 6'h00;
                for (int i = 0; i < 8; i++) begin
                    m_since[m][i] <= 1000;
                    m_last[m][i]  <= 1'b0;
                end
            end
            for (int k = 0; k < 3; k++) m_hist[k] <= 6'h00;
        end else begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 6; i < 8; i++) begin
                    if (m_ddr[m][i]) begin
                        m_since[m][i] <= 0;
                        m_last[m][i]  <= m_data[m][i];
                    end else if (m_since[m][i] < 1000) begin
                        m_since[m][i] <= m_since[m][i] + 1;
                    end
                end
                m_flag[m] <= (m_flag[m] & ~((m_wr(m) && m_off(m) == 2'd2) ? data_in[5:0] : 6'h00))
                             | m_det(m);
                if (m_wr(m) && m_off(m) == 2'd0) m_ddr[m]  <= data_in;
                if (m_wr(m) && m_off(m) == 2'd1) m_data[m] <= data_in;
                if (m_wr(m) && m_off(m) == 2'd3) m_mask[m] <= data_in[5:0];
            end
            m_hist[0] <= pin_in;
            m_hist[1] <= m_hist[0];
            m_hist[2] <= m_hist[1];
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int m, input logic [7:0] dout, input logic s,
                            input logic [5:0] po, input logic [5:0] oe, input logic irq);
        chk($sformatf("u%0d.data_out", m), dout, m_read(m));
        chk($sformatf("u%0d.sel", m), {7'b0, s}, {7'b0, m_sel(m)});
        chk($sformatf("u%0d.pin_out", m), {2'b0, po}, {2'b0, m_data[m][5:0]});
        chk($sformatf("u%0d.pin_oe", m), {2'b0, oe}, {2'b0, m_ddr[m][5:0]});
        chk($sformatf("u%0d.irq_n", m), {7'b0, irq}, {7'b0, ~|(m_flag[m] & m_mask[m])});
    endtask

    // One negedge: compare everything at the posedge, return 2 units after the negedge.
    task automatic tick();
        @(posedge phi2);
        cmp_inst(0, d0_out, s0, po0, oe0, irq0);
        cmp_inst(1, d1_out, s1, po1, oe1, irq1);
        @(negedge phi2);
        #2;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        r_w     = 1'b0;
        aec     = 1'b1;
        tick();
        r_w     = 1'b1;
        address = 16'h0100;
    endtask

    initial begin
        rst_n   = 1'b0;
        address = 16'h0100;
        r_w     = 1'b1;
        aec     = 1'b1;
        data_in = 8'h00;
        pin_in  = 6'h3F;
        @(negedge phi2);
        #2;
        tick();
        tick();
        address = 16'h0000;
        #1;
        chk("rst data_out", d0_out, 8'h00);
        chk("rst pin_oe", {2'b0, oe0}, 8'h00);
        chk("rst pin_out", {2'b0, po0}, 8'h00);
        chk("rst irq_n", {7'b0, irq0}, 8'h01);
        rst_n = 1'b1;
        tick();
        tick();

        // DDR/DATA defaults, readback, IMASK upper bits forced low
        wr(16'h0000, 8'h2F);
        wr(16'h0001, 8'h37);
        chk("t1 pin_oe", {2'b0, oe0}, 8'h2F);
        chk("t1 pin_out", {2'b0, po0}, 8'h37);
        address = 16'h0000;
        #1;
        chk("t1 u0 ddr rd", d0_out, 8'h2F);
        chk("t1 u1 ddr rd", d1_out, 8'h2F);
        wr(16'h0003, 8'hFF);
        address = 16'h0003;
        #1;
        chk("t1 imask rd", d0_out, 8'h3F);
        chk("t1 u1 no sel", {7'b0, s1}, 8'h00);

        // Synchroniser latency and falling-edge flag
        wr(16'h0000, 8'h00);
        address = 16'h0001;
        #1;
        chk("t2 data e0", d0_out, 8'h3F);
        pin_in = 6'h3E;
        tick();
        chk("t2 data e1", d0_out, 8'h3F);
        chk("t2 irq e1", {7'b0, irq0}, 8'h01);
        tick();
        chk("t2 data e2", d0_out, 8'h3E);
        chk("t2 irq e2", {7'b0, irq0}, 8'h01);
        tick();
        chk("t3 irq e3", {7'b0, irq0}, 8'h00);
        address = 16'h0002;
        #1;
        chk("t3 iflag rd", d0_out, 8'h01);
        wr(16'h0002, 8'h01);
        chk("t3 w1c irq", {7'b0, irq0}, 8'h01);
        pin_in = 6'h3F;
        tick();
        tick();
        tick();
        pin_in = 6'h3E;
        tick();
        tick();
        wr(16'h0002, 8'h01);
        chk("t3 set wins irq", {7'b0, irq0}, 8'h00);
        address = 16'h0002;
        #1;
        chk("t3 set wins flag", d0_out, 8'h01);

        // Fade on pinless bits 7:6
        wr(16'h0000, 8'hC0);
        wr(16'h0001, 8'hC0);
        chk("t4 pin_out", {2'b0, po0}, 8'h00);
        address = 16'h0001;
        #1;
        chk("t4 data driven", d0_out, 8'hFE);
        wr(16'h0000, 8'h00);
        address = 16'h0001;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("t4 u0 fade %0d", k), d0_out, (k < 4) ? 8'hFE : 8'h3E);
            chk($sformatf("t4 u1 nofade %0d", k), d1_out, 8'h3E);
            tick();
        end

        // 6510 decode: offset 2 outside the window; aec low blocks writes
        address = 16'h0002;
        data_in = 8'hFE;
        r_w     = 1'b0;
        #1;
        chk("t5 u1 sel", {7'b0, s1}, 8'h00);
        tick();
        aec     = 1'b0;
        address = 16'h0001;
        data_in = 8'h55;
        tick();
        aec = 1'b1;
        r_w = 1'b1;
        #1;
        chk("t5 aec u0 pin_out", {2'b0, po0}, 8'h00);
        chk("t5 aec u1 pin_out", {2'b0, po1}, 8'h00);
        chk("t5 u1 data rd", d1_out, 8'h3E);

        // Asynchronous reset mid-cycle with irq pending and a write in flight
        wr(16'h0000, 8'h2F);
        address = 16'h0000;
        #1;
        chk("t6 pre ddr rd", d0_out, 8'h2F);
        chk("t6 pre irq", {7'b0, irq0}, 8'h00);
        address = 16'h0001;
        data_in = 8'hAA;
        r_w     = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6 irq_n", {7'b0, irq0}, 8'h01);
        chk("t6 pin_oe", {2'b0, oe0}, 8'h00);
        chk("t6 pin_out", {2'b0, po0}, 8'h00);
        r_w     = 1'b1;
        address = 16'h0000;
        #1;
        chk("t6 u0 data_out", d0_out, 8'h00);
        chk("t6 u1 data_out", d1_out, 8'h00);
        tick();
        tick();
        address = 16'h0001;
        rst_n   = 1'b1;
        #1;
        chk("t6 write aborted", {2'b0, po0}, 8'h00);
        tick();
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
